// File: rtl/octree_traverser_pkg.sv
// Shared types and constants for the octree traverser: FSM encoding,
// node-word field positions, error codes and the node-word decoder.
package octree_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_READ  = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam int LEAF_BIT  = 31;
  localparam int OCC_BIT   = 24;
  localparam int PAYLOAD_W = 24;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_DEPTH = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;

  typedef struct packed {
    logic                 is_leaf;
    logic                 occupied;
    logic [PAYLOAD_W-1:0] field;
  } node_t;

  // field is the payload for a leaf and child_base for an internal node
  function automatic node_t decode_node(input logic [31:0] word);
    node_t n;
    n.is_leaf  = word[LEAF_BIT];
    n.occupied = word[OCC_BIT];
    n.field    = word[PAYLOAD_W-1:0];
    return n;
  endfunction

endpackage

// File: rtl/octree_traverser_if.sv
// Query, ROM read-port and result signals of the octree traverser.
// The traverser uses the slave modport; its environment uses master.
interface octree_traverser_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int COORD_WIDTH   = 8
);
  localparam int DEPTH_W = $clog2(COORD_WIDTH + 1);

  logic                     req_valid;
  logic                     req_ready;
  logic [COORD_WIDTH-1:0]   req_x;
  logic [COORD_WIDTH-1:0]   req_y;
  logic [COORD_WIDTH-1:0]   req_z;
  logic [ADDRESS_WIDTH-1:0] rom_addr;
  logic                     rom_ren;
  logic [DATA_WIDTH-1:0]    rom_data;
  logic                     res_valid;
  logic                     res_ready;
  logic [23:0]              res_payload;
  logic                     res_occupied;
  logic [DEPTH_W-1:0]       res_depth;
  logic [1:0]               res_error;

  modport slave (
    input  req_valid, req_x, req_y, req_z, rom_data, res_ready,
    output req_ready, rom_addr, rom_ren, res_valid, res_payload,
           res_occupied, res_depth, res_error
  );

  modport master (
    output req_valid, req_x, req_y, req_z, rom_data, res_ready,
    input  req_ready, rom_addr, rom_ren, res_valid, res_payload,
           res_occupied, res_depth, res_error
  );
endinterface

// File: rtl/octree_traverser_octant_index.sv
// Selects the child octant {x[b], y[b], z[b]} for the current depth,
// where b = COORD_WIDTH-1-depth; yields 0 once depth runs past the coordinates.
module octant_index #(
  parameter int COORD_WIDTH = 8,
  parameter int DEPTH_W     = 4
) (
  input  logic [DEPTH_W-1:0]     i_depth,
  input  logic [COORD_WIDTH-1:0] i_x,
  input  logic [COORD_WIDTH-1:0] i_y,
  input  logic [COORD_WIDTH-1:0] i_z,
  output logic [2:0]             o_idx
);
  localparam int BIT_W = (COORD_WIDTH > 1) ? $clog2(COORD_WIDTH) : 1;

  logic             w_in_range;
  logic [BIT_W-1:0] w_bit;

  assign w_in_range = (i_depth < DEPTH_W'(COORD_WIDTH));
  assign w_bit      = BIT_W'(COORD_WIDTH - 1) - BIT_W'(i_depth);

  always_comb begin
    o_idx = 3'b000;
    if (w_in_range) begin
      o_idx = {i_x[w_bit], i_y[w_bit], i_z[w_bit]};
    end else begin
      o_idx = 3'b000;
    end
  end
endmodule

// File: rtl/octree_traverser.sv
// Walks the octree in octant_rom one level per ROM read until a leaf, a depth
// overflow or an out-of-range child block stops the walk, then holds the result.
module octree_traverser
  import octree_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int COORD_WIDTH   = 8,
  parameter int ROM_DEPTH     = 38,
  parameter int ROOT_ADDR     = 0
) (
  input logic               clk,
  input logic               rst,
  octree_traverser_if.slave bus
);
  localparam int DEPTH_W = $clog2(COORD_WIDTH + 1);

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DEPTH_W-1:0]       r_depth;
  logic [COORD_WIDTH-1:0]   r_x;
  logic [COORD_WIDTH-1:0]   r_y;
  logic [COORD_WIDTH-1:0]   r_z;
  logic [PAYLOAD_W-1:0]     r_payload;
  logic                     r_occupied;
  logic [1:0]               r_error;

  node_t                    w_node;
  logic [2:0]               w_idx;
  logic [ADDRESS_WIDTH-1:0] w_base;
  logic [ADDRESS_WIDTH:0]   w_last_child;
  logic                     w_range_err;
  logic                     w_depth_max;
  logic [ADDRESS_WIDTH-1:0] w_child_addr;

  octant_index #(
    .COORD_WIDTH(COORD_WIDTH),
    .DEPTH_W    (DEPTH_W)
  ) u_octant_index (
    .i_depth(r_depth),
    .i_x    (r_x),
    .i_y    (r_y),
    .i_z    (r_z),
    .o_idx  (w_idx)
  );

  assign w_node       = decode_node(bus.rom_data[31:0]);
  assign w_base       = ADDRESS_WIDTH'(w_node.field);
  // one extra bit so child_base + 7 cannot wrap past the top of the address space
  assign w_last_child = {1'b0, w_base} + (ADDRESS_WIDTH + 1)'(7);
  assign w_range_err  = (w_last_child > (ADDRESS_WIDTH + 1)'(ROM_DEPTH - 1));
  assign w_depth_max  = (r_depth == DEPTH_W'(COORD_WIDTH));
  assign w_child_addr = w_base + ADDRESS_WIDTH'(w_idx);

  assign bus.req_ready    = (r_state == S_IDLE);
  assign bus.rom_ren      = (r_state == S_ISSUE);
  assign bus.rom_addr     = r_addr;
  assign bus.res_valid    = (r_state == S_DONE);
  assign bus.res_payload  = r_payload;
  assign bus.res_occupied = r_occupied;
  assign bus.res_depth    = r_depth;
  assign bus.res_error    = r_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= {ADDRESS_WIDTH{1'b0}};
      r_depth    <= {DEPTH_W{1'b0}};
      r_x        <= {COORD_WIDTH{1'b0}};
      r_y        <= {COORD_WIDTH{1'b0}};
      r_z        <= {COORD_WIDTH{1'b0}};
      r_payload  <= {PAYLOAD_W{1'b0}};
      r_occupied <= 1'b0;
      r_error    <= ERR_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_x     <= bus.req_x;
            r_y     <= bus.req_y;
            r_z     <= bus.req_z;
            r_addr  <= ADDRESS_WIDTH'(ROOT_ADDR);
            r_depth <= {DEPTH_W{1'b0}};
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_READ;
        S_READ: begin
          // depth overflow is checked before range so a too-deep node reports depth
          if (w_node.is_leaf) begin
            r_payload  <= w_node.field;
            r_occupied <= w_node.occupied;
            r_error    <= ERR_OK;
            r_state    <= S_DONE;
          end else if (w_depth_max) begin
            r_payload  <= {PAYLOAD_W{1'b0}};
            r_occupied <= 1'b0;
            r_error    <= ERR_DEPTH;
            r_state    <= S_DONE;
          end else if (w_range_err) begin
            r_payload  <= {PAYLOAD_W{1'b0}};
            r_occupied <= 1'b0;
            r_error    <= ERR_RANGE;
            r_state    <= S_DONE;
          end else begin
            r_addr  <= w_child_addr;
            r_depth <= r_depth + DEPTH_W'(1);
            r_state <= S_ISSUE;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_octree_traverser.sv
// Scoreboard bench for octree_traverser: an 8-bit-coordinate instance for the
// main walks and a 2-bit-coordinate instance for the depth-overflow case.
module tb_octree_traverser;

  typedef struct {
    logic [23:0] payload;
    logic        occ;
    logic [3:0]  depth;
    logic [1:0]  err;
  } exp_t;

  logic clk;
  logic rst;

  logic [31:0] rom_a [0:37];
  logic [31:0] rom_b [0:37];
  logic [31:0] rd_q [$];
  int          rd_cnt_b;
  exp_t        exp_q [$];
  int          n_cmp;
  int          n_bad;

  octree_traverser_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .COORD_WIDTH(8)) bus_a ();
  octree_traverser_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .COORD_WIDTH(2)) bus_b ();

  octree_traverser #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .COORD_WIDTH(8), .ROM_DEPTH(38), .ROOT_ADDR(0)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  octree_traverser #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .COORD_WIDTH(2), .ROM_DEPTH(38), .ROOT_ADDR(0)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle-latency ROM models; out-of-range addresses read as zero
  always @(posedge clk) begin
    if (bus_a.rom_ren) begin
      bus_a.rom_data <= (bus_a.rom_addr < 32'd38) ? rom_a[bus_a.rom_addr[5:0]] : 32'h0;
      rd_q.push_back(bus_a.rom_addr);
    end
    if (bus_b.rom_ren) begin
      bus_b.rom_data <= (bus_b.rom_addr < 32'd38) ? rom_b[bus_b.rom_addr[5:0]] : 32'h0;
      rd_cnt_b = rd_cnt_b + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_rom_a();
    for (int i = 0; i < 38; i++) rom_a[i] = 32'h0;
  endtask

  task automatic compare_result(input string tag, input logic [23:0] pl, input logic oc,
                                input logic [3:0] dp, input logic [1:0] er);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_payload"}, {8'd0, pl}, {8'd0, e.payload});
      check_val({tag, "_occupied"}, {31'd0, oc}, {31'd0, e.occ});
      check_val({tag, "_depth"}, {28'd0, dp}, {28'd0, e.depth});
      check_val({tag, "_error"}, {30'd0, er}, {30'd0, e.err});
    end
  endtask

  // one query on instance A: accept, latency, optional stall in DONE, scoreboard, release
  task automatic run_a(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] z, input exp_t e, input int lat, input int hold);
    int cyc;
    bus_a.req_x     = x;
    bus_a.req_y     = y;
    bus_a.req_z     = z;
    bus_a.req_valid = 1'b1;
    check_val({tag, "_req_ready"}, {31'd0, bus_a.req_ready}, 32'd1);
    rd_q.delete();
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    cyc = 1;
    check_val({tag, "_ren_c1"}, {31'd0, bus_a.rom_ren}, 32'd1);
    check_val({tag, "_addr_c1"}, bus_a.rom_addr, 32'd0);
    while (!bus_a.res_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc = cyc + 1;
    end
    check_val({tag, "_latency"}, cyc, lat);
    for (int h = 0; h < hold; h++) begin
      check_val({tag, "_hold_valid"}, {31'd0, bus_a.res_valid}, 32'd1);
      check_val({tag, "_hold_ready"}, {31'd0, bus_a.req_ready}, 32'd0);
      check_val({tag, "_hold_payload"}, {8'd0, bus_a.res_payload}, {8'd0, e.payload});
      check_val({tag, "_hold_depth"}, {28'd0, bus_a.res_depth}, {28'd0, e.depth});
      check_val({tag, "_hold_error"}, {30'd0, bus_a.res_error}, {30'd0, e.err});
      @(posedge clk); #1;
    end
    bus_a.res_ready = 1'b1;
    compare_result(tag, bus_a.res_payload, bus_a.res_occupied, bus_a.res_depth, bus_a.res_error);
    @(posedge clk); #1;
    bus_a.res_ready = 1'b0;
    check_val({tag, "_idle_ready"}, {31'd0, bus_a.req_ready}, 32'd1);
    check_val({tag, "_idle_valid"}, {31'd0, bus_a.res_valid}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   cyc;
    n_cmp    = 0;
    n_bad    = 0;
    rd_cnt_b = 0;
    rst      = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_x = 8'd0; bus_a.req_y = 8'd0; bus_a.req_z = 8'd0;
    bus_a.res_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_x = 2'd0; bus_b.req_y = 2'd0; bus_b.req_z = 2'd0;
    bus_b.res_ready = 1'b0;
    clear_rom_a();
    for (int i = 0; i < 38; i++) rom_b[i] = 32'h0;
    #1;
    check_val("rst_req_ready", {31'd0, bus_a.req_ready}, 32'd1);
    check_val("rst_rom_ren", {31'd0, bus_a.rom_ren}, 32'd0);
    check_val("rst_rom_addr", bus_a.rom_addr, 32'd0);
    check_val("rst_res_valid", {31'd0, bus_a.res_valid}, 32'd0);
    check_val("rst_payload", {8'd0, bus_a.res_payload}, 32'd0);
    check_val("rst_occupied", {31'd0, bus_a.res_occupied}, 32'd0);
    check_val("rst_depth", {28'd0, bus_a.res_depth}, 32'd0);
    check_val("rst_error", {30'd0, bus_a.res_error}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // root leaf
    rom_a[0] = 32'h8100_00AB;
    e = '{payload: 24'h0000AB, occ: 1'b1, depth: 4'd0, err: 2'd0};
    run_a("root_leaf", 8'h00, 8'h00, 8'h00, e, 3, 0);

    // one level down, octant 4 from x MSB
    clear_rom_a();
    rom_a[0] = 32'h0000_0001;
    rom_a[5] = 32'h8100_0042;
    e = '{payload: 24'h000042, occ: 1'b1, depth: 4'd1, err: 2'd0};
    run_a("one_level", 8'h80, 8'h00, 8'h00, e, 5, 0);
    check_val("one_level_nreads", rd_q.size(), 32'd2);
    if (rd_q.size() == 2) check_val("one_level_addr2", rd_q[1], 32'd5);

    // child block 31..38 overruns a 38-word ROM
    clear_rom_a();
    rom_a[0] = 32'h0000_001F;
    e = '{payload: 24'h000000, occ: 1'b0, depth: 4'd0, err: 2'd2};
    run_a("range_err", 8'h12, 8'h34, 8'h56, e, 3, 0);
    check_val("range_err_nreads", rd_q.size(), 32'd1);

    // two levels, unoccupied leaf, stalled 10 cycles in DONE
    clear_rom_a();
    rom_a[0]  = 32'h0000_0001;
    rom_a[6]  = 32'h0000_0010;
    rom_a[20] = 32'h8000_1234;
    e = '{payload: 24'h001234, occ: 1'b0, depth: 4'd2, err: 2'd0};
    run_a("stall", 8'hC0, 8'h00, 8'h80, e, 7, 10);

    // back-to-back: child block 30..37 is exactly in range
    clear_rom_a();
    rom_a[0]  = 32'h0000_001E;
    rom_a[37] = 32'h8100_0077;
    e = '{payload: 24'h000077, occ: 1'b1, depth: 4'd1, err: 2'd0};
    run_a("edge_range", 8'hE0, 8'hE0, 8'hE0, e, 5, 0);

    // reset while reading at depth 1
    clear_rom_a();
    rom_a[0]  = 32'h0000_0001;
    rom_a[1]  = 32'h0000_0010;
    rom_a[16] = 32'h8100_0099;
    bus_a.req_x = 8'h00; bus_a.req_y = 8'h00; bus_a.req_z = 8'h00;
    bus_a.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("mid_read_ren", {31'd0, bus_a.rom_ren}, 32'd0);
    check_val("mid_read_ready", {31'd0, bus_a.req_ready}, 32'd0);
    check_val("mid_read_addr", bus_a.rom_addr, 32'd1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_ren", {31'd0, bus_a.rom_ren}, 32'd0);
    check_val("mid_rst_valid", {31'd0, bus_a.res_valid}, 32'd0);
    check_val("mid_rst_ready", {31'd0, bus_a.req_ready}, 32'd1);
    check_val("mid_rst_addr", bus_a.rom_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    e = '{payload: 24'h000099, occ: 1'b1, depth: 4'd2, err: 2'd0};
    run_a("after_rst", 8'h00, 8'h00, 8'h00, e, 7, 0);

    // 2-bit coordinates: internal nodes 0 -> 1 -> 9, node 9 still internal
    rom_b[0] = 32'h0000_0001;
    rom_b[1] = 32'h0000_0009;
    rom_b[9] = 32'h0000_0000;
    rd_cnt_b = 0;
    bus_b.req_valid = 1'b1;
    exp_q.push_back('{payload: 24'h000000, occ: 1'b0, depth: 4'd2, err: 2'd1});
    @(posedge clk); #1;
    bus_b.req_valid = 1'b0;
    cyc = 1;
    while (!bus_b.res_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc = cyc + 1;
    end
    check_val("depth_ovf_latency", cyc, 32'd7);
    check_val("depth_ovf_nreads", rd_cnt_b, 32'd3);
    bus_b.res_ready = 1'b1;
    compare_result("depth_ovf", bus_b.res_payload, bus_b.res_occupied,
                   {2'd0, bus_b.res_depth}, bus_b.res_error);
    @(posedge clk); #1;
    bus_b.res_ready = 1'b0;
    check_val("depth_ovf_idle", {31'd0, bus_b.req_ready}, 32'd1);

    check_val("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/octree_traverser.md
Name: octree_traverser

Overview:
- Walks the octree stored in octant_rom to find the leaf that contains a query point.
- Accepts an (x,y,z) request on a valid/ready interface and drives the ROM read port (addr1/ren), one node per level.
- Decodes each node word from dout1 and returns the leaf payload, depth reached and an error code on a valid/ready result interface.
- Sits between the ray-step/march logic (upstream) and octant_rom (downstream).

Parameters:
- ADDRESS_WIDTH, 32, width of the ROM address port (matches octant_rom).
- DATA_WIDTH, 32, width of a ROM node word (matches octant_rom).
- COORD_WIDTH, 8, bits per coordinate axis; this is also the maximum tree depth.
- ROM_DEPTH, 38, number of valid ROM words; addresses 0..ROM_DEPTH-1.
- ROOT_ADDR, 0, ROM address of the root node.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  query present
- req_ready  out  1  traverser idle, can accept a query
- req_x / req_y / req_z  in  COORD_WIDTH each  query point
- rom_addr  out  ADDRESS_WIDTH  to octant_rom addr1
- rom_ren  out  1  to octant_rom ren
- rom_data  in  DATA_WIDTH  from octant_rom dout1
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result
- res_payload  out  24  leaf payload
- res_occupied  out  1  leaf bit 24
- res_depth  out  $clog2(COORD_WIDTH+1)  level of the leaf (root = 0)
- res_error  out  2  0 = ok, 1 = depth overflow, 2 = child address out of range

Behaviour:
- Node word format:
  - bit31 = 1 (leaf): bit24 is the occupied flag, bits[23:0] are the payload.
  - bit31 = 0 (internal): bits[23:0] are child_base, zero-extended to ADDRESS_WIDTH. Child i is at child_base + i.
- Octant index at depth d is {x[b], y[b], z[b]}, where b = COORD_WIDTH-1-d. x is the MSB of the index.
- The ROM has 1-cycle read latency: rom_data is sampled in the cycle after rom_ren was high.
- FSM states are IDLE, ISSUE, READ, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch the coordinates, set addr = ROOT_ADDR and depth = 0, go to ISSUE.
- ISSUE: rom_ren = 1, rom_addr = addr, go to READ.
- READ: decode rom_data.
  - Leaf: latch payload and occupied, error = 0, go to DONE.
  - Internal with depth == COORD_WIDTH: error = 1, payload = 0, go to DONE.
  - Internal with child_base + 7 > ROM_DEPTH-1: error = 2, payload = 0, go to DONE. The comparison is done at ADDRESS_WIDTH+1 bits so it cannot wrap.
  - Otherwise: addr = child_base + index, depth = depth + 1, go to ISSUE.
- DONE:
  - res_valid = 1; all res_* outputs are held stable.
  - On res_ready: go to IDLE.
- Latency: 2 cycles per level plus 1 cycle of acceptance. A root leaf gives res_valid 3 cycles after the accept edge; each extra level adds 2.
- rom_ren is high only in ISSUE. rom_addr holds its last value otherwise.
- req_ready is 0 outside IDLE; req_valid in those states is ignored (no queuing).
- res_depth reports the depth at which decoding stopped, including in error cases.
- Reset (asynchronous, any state, including mid-walk): state = IDLE and all result registers cleared.
  - req_ready = 1, rom_ren = 0, rom_addr = 0.
  - res_valid = 0, res_payload = 0, res_occupied = 0, res_depth = 0, res_error = 0.
  - A ROM read in flight is discarded.

Decomposition:
- Package octree_pkg holds:
  - the fsm state typedef;
  - constants LEAF_BIT = 31, OCC_BIT = 24, PAYLOAD_W = 24;
  - error code constants ERR_OK, ERR_DEPTH, ERR_RANGE;
  - a node-decode function returning {is_leaf, occupied, field}.
- One natural sub-module, octant_index, combinationally selects bit b of each coordinate for the current depth. Everything else stays in the top module.

Test Plan:
- ROM[0] = 0x8100_00AB; query (0,0,0); accept at cycle 0.
  → rom_ren high in cycle 1 with addr 0.
  → res_valid in cycle 3: payload 0xAB, occupied 1, depth 0, error 0.
- ROM[0] = 0x0000_0001, ROM[5] = 0x8100_0042; query x = 0x80, y = 0, z = 0.
  → second read at addr 5 (index 4).
  → res_valid in cycle 5: payload 0x42, depth 1, error 0.
- ROM[0] = 0x0000_001F (child_base 31; 31 + 7 = 38 > 37).
  → error 2, depth 0, only one ROM read issued.
- COORD_WIDTH = 2; chain of internal nodes at addresses 0 → 1 → 9, with ROM[9] internal.
  → error 1, depth 2.
- Hold res_ready = 0 for 10 cycles in DONE.
  → res_* stable and req_ready = 0 throughout.
  → res_ready = 1 returns to IDLE next cycle; a back-to-back request is accepted.
- Assert rst while in READ at depth 1.
  → immediately rom_ren = 0, res_valid = 0, req_ready = 1.
  → a new query after reset completes correctly.
